// File: rtl/sample_expander_v2.sv
// sample_expander_v2: two-stage valid/ready expander that left-justifies WIDTH_IN samples onto a wider grid.
module sample_expander_v2 #(
    parameter int   WIDTH_IN      = 16,
    parameter int   WIDTH_OUT_MAX = 32,
    parameter logic IS_SIGNED     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [5:0]               width_out,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH_IN-1:0]      s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH_OUT_MAX-1:0] m_data,
    output logic                     cfg_err
);
    localparam int SW = $clog2(WIDTH_OUT_MAX - WIDTH_IN + 1);
    localparam logic [SW-1:0] SH_MAX = SW'(WIDTH_OUT_MAX - WIDTH_IN);

    logic                     v1_q, v1_d;
    logic [WIDTH_IN-1:0]      d1_q, d1_d;
    logic [SW-1:0]            sh1_q, sh1_d;
    logic                     mv_q, mv_d;
    logic [WIDTH_OUT_MAX-1:0] md_q, md_d;
    logic                     err_q, err_d;
    logic                     lo, hi, in_fire, s1_load, s2_load;
    logic [SW-1:0]            sh_in;
    logic [WIDTH_OUT_MAX-1:0] ext;

    assign s_ready = ena & rst_n & (!v1_q | !mv_q | m_ready);
    assign m_valid = mv_q;
    assign m_data  = md_q;
    assign cfg_err = err_q;

    // Clamp the requested width into a shift, extend and shift the staged sample, and advance both stages.
    always_comb begin
        lo      = {1'b0, width_out} < 7'(WIDTH_IN);
        hi      = {1'b0, width_out} > 7'(WIDTH_OUT_MAX);
        sh_in   = lo ? '0 : hi ? SH_MAX : SW'(width_out - 6'(WIDTH_IN));
        in_fire = s_valid & s_ready;
        s2_load = ena & (!mv_q | m_ready);
        s1_load = ena & (!v1_q | s2_load);
        ext     = {{(WIDTH_OUT_MAX - WIDTH_IN){IS_SIGNED & d1_q[WIDTH_IN-1]}}, d1_q};
        v1_d    = s1_load ? in_fire : v1_q;
        d1_d    = in_fire ? s_data : d1_q;
        sh1_d   = in_fire ? sh_in : sh1_q;
        mv_d    = s2_load ? v1_q : mv_q;
        md_d    = (s2_load & v1_q) ? ext << sh1_q : md_q;
        err_d   = err_q | (in_fire & (lo | hi));
    end

    // Pipeline and sticky error registers; reset discards both stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            sh1_q <= '0;
            mv_q  <= 1'b0;
            md_q  <= '0;
            err_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            d1_q  <= d1_d;
            sh1_q <= sh1_d;
            mv_q  <= mv_d;
            md_q  <= md_d;
            err_q <= err_d;
        end
    end
endmodule
